// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg : shared widths, writeback entry type and sign/zero helper
// Rev 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int MULT_PROD_W = 64;
  localparam int REG_ADDR_W  = 5;
  localparam int DATA_W      = 32;

  typedef struct packed {
    logic [MULT_PROD_W-1:0] result;
    logic [REG_ADDR_W-1:0]  regdest;
  } mult_entry_t;

  // Turns the upstream magnitude plus sign/zero flags into the signed product.
  function automatic logic [MULT_PROD_W-1:0] signed_result(
    input logic [MULT_PROD_W-1:0] magnitude,
    input logic                   ispositive,
    input logic                   iszero
  );
    logic [MULT_PROD_W-1:0] res;
    if (iszero) begin
      res = '0;
    end else if (ispositive) begin
      res = magnitude;
    end else begin
      res = (~magnitude) + {{(MULT_PROD_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_wb_fifo.sv
// ============================================================================
// mult_wb_fifo : valid/ready FIFO of completed multiply results awaiting writeback
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_wb_fifo
  import mult_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  mult_entry_t            in_entry,
  output logic                   out_valid,
  input  logic                   out_ready,
  output mult_entry_t            out_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  mult_entry_t   mem_q [DEPTH];
  mult_entry_t   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // Full/empty come only from the registered count, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_entry = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/mult_final.sv
// ============================================================================
// mult_final : final multiply stage - sign/zero correction and writeback buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module mult_final
  import mult_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        m1_mf_oper,
  input  logic [MULT_PROD_W-1:0]      m1_mf_product,
  input  logic [REG_ADDR_W-1:0]       m1_mf_regdest,
  input  logic                        m1_mf_ispositive,
  input  logic                        m1_mf_iszero,
  output logic                        mf_m1_stall,
  output logic                        mf_wb_oper,
  output logic [DATA_W-1:0]           mf_wb_data,
  output logic [DATA_W-1:0]           mf_wb_datahi,
  output logic [REG_ADDR_W-1:0]       mf_wb_regdest,
  input  logic                        mf_wb_ready,
  output logic [$clog2(FIFO_DEPTH):0] mf_count
);

  mult_entry_t in_entry;
  mult_entry_t head_entry;
  logic        in_ready;
  logic        out_valid;
  logic        enq_valid;

  always_comb begin
    in_entry.result  = signed_result(m1_mf_product, m1_mf_ispositive, m1_mf_iszero);
    in_entry.regdest = m1_mf_regdest;
  end

  // Writes to r0 are consumed like any other bundle but never buffered.
  assign enq_valid = m1_mf_oper && (m1_mf_regdest != '0);

  mult_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (enq_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .out_valid (out_valid),
    .out_ready (mf_wb_ready),
    .out_entry (head_entry),
    .count     (mf_count)
  );

  assign mf_m1_stall   = !in_ready;
  assign mf_wb_oper    = out_valid;
  assign mf_wb_data    = out_valid ? head_entry.result[DATA_W-1:0]            : '0;
  assign mf_wb_datahi  = out_valid ? head_entry.result[MULT_PROD_W-1:DATA_W]  : '0;
  assign mf_wb_regdest = out_valid ? head_entry.regdest                        : '0;

endmodule

`default_nettype wire

// File: tb/tb_mult_final.sv
// ============================================================================
// tb_mult_final : directed scenarios plus randomized traffic against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mult_final;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          reset;
  logic          m1_mf_oper;
  logic [63:0]   m1_mf_product;
  logic [4:0]    m1_mf_regdest;
  logic          m1_mf_ispositive;
  logic          m1_mf_iszero;
  logic          mf_m1_stall;
  logic          mf_wb_oper;
  logic [31:0]   mf_wb_data;
  logic [31:0]   mf_wb_datahi;
  logic [4:0]    mf_wb_regdest;
  logic          mf_wb_ready;
  logic [CW-1:0] mf_count;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
  } ent_t;
  ent_t model_q[$];

  mult_final #(.FIFO_DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .m1_mf_oper       (m1_mf_oper),
    .m1_mf_product    (m1_mf_product),
    .m1_mf_regdest    (m1_mf_regdest),
    .m1_mf_ispositive (m1_mf_ispositive),
    .m1_mf_iszero     (m1_mf_iszero),
    .mf_m1_stall      (mf_m1_stall),
    .mf_wb_oper       (mf_wb_oper),
    .mf_wb_data       (mf_wb_data),
    .mf_wb_datahi     (mf_wb_datahi),
    .mf_wb_regdest    (mf_wb_regdest),
    .mf_wb_ready      (mf_wb_ready),
    .mf_count         (mf_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic oper, input logic [63:0] p, input logic [4:0] rd,
                       input logic pos, input logic zero);
    m1_mf_oper       = oper;
    m1_mf_product    = p;
    m1_mf_regdest    = rd;
    m1_mf_ispositive = pos;
    m1_mf_iszero     = zero;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    mf_wb_ready = 1'b0;
    drive(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
    #1;
    total++; if (mf_wb_oper !== 1'b0) $display("FAIL reset_oper: got %b want 0", mf_wb_oper); else passed++;
    total++; if ({mf_wb_datahi, mf_wb_data} !== 64'd0) $display("FAIL reset_data: got %h want 0", {mf_wb_datahi, mf_wb_data}); else passed++;
    total++; if (mf_m1_stall !== 1'b0 || mf_count !== '0 || mf_wb_regdest !== 5'd0)
      $display("FAIL reset_ctrl: stall=%b count=%0d rd=%0d want 0/0/0", mf_m1_stall, mf_count, mf_wb_regdest); else passed++;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_positive();
    mf_wb_ready = 1'b1;
    drive(1'b1, 64'd42, 5'd3, 1'b1, 1'b0);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
    total++; if (mf_wb_oper !== 1'b1) $display("FAIL pos_oper: got %b want 1", mf_wb_oper); else passed++;
    total++; if (mf_wb_data !== 32'h2A || mf_wb_datahi !== 32'h0)
      $display("FAIL pos_data: got %h_%h want 00000000_0000002a", mf_wb_datahi, mf_wb_data); else passed++;
    total++; if (mf_wb_regdest !== 5'd3) $display("FAIL pos_rd: got %0d want 3", mf_wb_regdest); else passed++;
    tick();
    total++; if (mf_wb_oper !== 1'b0 || mf_count !== '0)
      $display("FAIL pos_dequeue: oper=%b count=%0d want 0/0", mf_wb_oper, mf_count); else passed++;
  endtask

  task automatic test_negative();
    mf_wb_ready = 1'b0;
    drive(1'b1, 64'd6, 5'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
    total++; if (mf_wb_data !== 32'hFFFF_FFFA || mf_wb_datahi !== 32'hFFFF_FFFF)
      $display("FAIL neg_data: got %h_%h want ffffffff_fffffffa", mf_wb_datahi, mf_wb_data); else passed++;
    total++; if (mf_wb_regdest !== 5'd7 || mf_wb_oper !== 1'b1)
      $display("FAIL neg_rd: rd=%0d oper=%b want 7/1", mf_wb_regdest, mf_wb_oper); else passed++;
    mf_wb_ready = 1'b1;
    tick();
  endtask

  task automatic test_zero_and_r0();
    mf_wb_ready = 1'b0;
    drive(1'b1, 64'd99, 5'd4, 1'b0, 1'b1);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
    total++; if (mf_wb_data !== 32'h0 || mf_wb_datahi !== 32'h0 || mf_wb_regdest !== 5'd4 || mf_wb_oper !== 1'b1)
      $display("FAIL zero_data: got %h_%h rd=%0d oper=%b want 0_0 rd=4 oper=1",
               mf_wb_datahi, mf_wb_data, mf_wb_regdest, mf_wb_oper); else passed++;
    mf_wb_ready = 1'b1;
    tick();
    drive(1'b1, {$urandom, $urandom}, 5'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
    total++; if (mf_wb_oper !== 1'b0 || mf_count !== '0)
      $display("FAIL r0_discard: oper=%b count=%0d want 0/0", mf_wb_oper, mf_count); else passed++;
  endtask

  task automatic test_stall_order();
    mf_wb_ready = 1'b0;
    drive(1'b1, 64'd100, 5'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'd200, 5'd2, 1'b1, 1'b0);
    tick();
    total++; if (mf_m1_stall !== 1'b1 || mf_count !== CW'(2))
      $display("FAIL stall_full: stall=%b count=%0d want 1/2", mf_m1_stall, mf_count); else passed++;
    drive(1'b1, 64'd300, 5'd3, 1'b1, 1'b0);
    tick();
    total++; if (mf_count !== CW'(2) || mf_wb_regdest !== 5'd1 || mf_wb_data !== 32'd100)
      $display("FAIL stall_hold: count=%0d rd=%0d data=%0d want 2/1/100", mf_count, mf_wb_regdest, mf_wb_data); else passed++;
    mf_wb_ready = 1'b1;
    tick();
    total++; if (mf_m1_stall !== 1'b0 || mf_count !== CW'(1) || mf_wb_regdest !== 5'd2)
      $display("FAIL stall_release: stall=%b count=%0d rd=%0d want 0/1/2", mf_m1_stall, mf_count, mf_wb_regdest); else passed++;
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
    total++; if (mf_count !== CW'(1) || mf_wb_regdest !== 5'd3 || mf_wb_data !== 32'd300)
      $display("FAIL stall_third: count=%0d rd=%0d data=%0d want 1/3/300", mf_count, mf_wb_regdest, mf_wb_data); else passed++;
    tick();
    total++; if (mf_count !== '0 || mf_wb_oper !== 1'b0)
      $display("FAIL stall_drain: count=%0d oper=%b want 0/0", mf_count, mf_wb_oper); else passed++;
  endtask

  task automatic test_back_to_back();
    mf_wb_ready = 1'b0;
    drive(1'b1, 64'd11, 5'd5, 1'b1, 1'b0);
    tick();
    total++; if (mf_count !== CW'(1)) $display("FAIL b2b_first: count=%0d want 1", mf_count); else passed++;
    drive(1'b1, 64'd22, 5'd6, 1'b1, 1'b0);
    mf_wb_ready = 1'b1;
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
    total++; if (mf_count !== CW'(1) || mf_wb_regdest !== 5'd6 || mf_wb_data !== 32'd22)
      $display("FAIL b2b_swap: count=%0d rd=%0d data=%0d want 1/6/22", mf_count, mf_wb_regdest, mf_wb_data); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    mf_wb_ready = 1'b0;
    drive(1'b1, 64'd9, 5'd9, 1'b1, 1'b0);
    tick();
    drive(1'b1, 64'd10, 5'd10, 1'b1, 1'b0);
    tick();
    drive(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
    total++; if (mf_count !== CW'(2)) $display("FAIL rmid_fill: count=%0d want 2", mf_count); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (mf_wb_oper !== 1'b0 || mf_count !== '0 || mf_m1_stall !== 1'b0 ||
                 {mf_wb_datahi, mf_wb_data} !== 64'd0 || mf_wb_regdest !== 5'd0)
      $display("FAIL rmid_async: oper=%b count=%0d stall=%b data=%h rd=%0d want all 0",
               mf_wb_oper, mf_count, mf_m1_stall, {mf_wb_datahi, mf_wb_data}, mf_wb_regdest); else passed++;
    @(posedge clock);
    #1;
    reset       = 1'b1;
    mf_wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (mf_wb_oper !== 1'b0) $display("FAIL rmid_ghost: cycle %0d oper=%b want 0", i, mf_wb_oper); else passed++;
    end
  endtask

  task automatic test_random();
    logic [63:0] p, exp_res;
    logic [4:0]  rd, exp_rd;
    logic        oper, pos, zero, exp_oper, acc, deq;
    int          sz;
    model_q.delete();
    for (int i = 0; i < 400; i++) begin
      oper = ($urandom_range(0, 3) != 0);
      pos  = 1'($urandom_range(0, 1));
      zero = ($urandom_range(0, 7) == 0);
      rd   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      p    = {$urandom, $urandom};
      drive(oper, p, rd, pos, zero);
      mf_wb_ready = ($urandom_range(0, 2) != 0);
      sz       = model_q.size();
      exp_oper = (sz != 0);
      exp_res  = (sz != 0) ? model_q[0].res : 64'd0;
      exp_rd   = (sz != 0) ? model_q[0].rd  : 5'd0;
      total++; if (mf_wb_oper !== exp_oper) $display("FAIL rnd_oper[%0d]: got %b want %b", i, mf_wb_oper, exp_oper); else passed++;
      total++; if ({mf_wb_datahi, mf_wb_data} !== exp_res)
        $display("FAIL rnd_data[%0d]: got %h want %h", i, {mf_wb_datahi, mf_wb_data}, exp_res); else passed++;
      total++; if (mf_wb_regdest !== exp_rd) $display("FAIL rnd_rd[%0d]: got %0d want %0d", i, mf_wb_regdest, exp_rd); else passed++;
      total++; if (mf_count !== CW'(sz) || mf_m1_stall !== (sz == DEPTH))
        $display("FAIL rnd_count[%0d]: count=%0d stall=%b want %0d/%b", i, mf_count, mf_m1_stall, sz, (sz == DEPTH)); else passed++;
      acc = oper && (sz != DEPTH);
      deq = (sz != 0) && mf_wb_ready;
      if (deq) void'(model_q.pop_front());
      if (acc && rd != 5'd0) begin
        if (zero)     model_q.push_back('{res: 64'd0, rd: rd});
        else if (pos) model_q.push_back('{res: p, rd: rd});
        else          model_q.push_back('{res: 64'd0 - p, rd: rd});
      end
      tick();
    end
    drive(1'b0, 64'd0, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative();
    test_zero_and_r0();
    test_stall_order();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
